plb_lookup_queue: RTL and testbench
===================================

Name: plb_lookup_queue

Overview:
Parametrised successor of the single-slot PLB lookup stage in the MPT walker pipeline. It accepts walker transactions and issues read lookups to the PLB over a MEM/SRAM-style master port, keeping up to DEPTH lookups in flight. Results return in order and are buffered per transaction. Each transaction leaves with its walking bit set to SKIP on a hit or DO on a miss. Adds a bypass mode, a flush that is safe with lookups in flight, and saturating hit/miss counters.

Parameters:
DATA_WIDTH, 32, width of the pipeline transaction word.
KEY_LSB, 0, LSB of the lookup key (SDID, spa, access_type) inside the transaction.
KEY_WIDTH, 32, width of the key and of plb_cache_mem_addr.
WALK_BIT, 0, index of the walking flag in the transaction; 1 means MPT_WALKING_SKIP, 0 means MPT_WALKING_DO.
DEPTH, 4, maximum transactions held (in flight plus buffered); power of two, at least 2.
CNT_WIDTH, 16, width of the hit and miss counters.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
plb_lookup_slave_valid  in  1  input transaction valid
plb_lookup_slave_ready  out  1  input accepted this cycle
plb_lookup_slave_data  in  DATA_WIDTH  input transaction
plb_lookup_master_valid  out  1  output transaction valid
plb_lookup_master_ready  in  1  downstream ready
plb_lookup_master_data  out  DATA_WIDTH  transaction with walking bit resolved
plb_lookup_control_flush  in  1  drop all held transactions
plb_en_i  in  1  1 = look up in PLB; 0 = bypass, always resolve to DO
plb_cache_mem_req  out  1  lookup request
plb_cache_mem_gnt  in  1  request granted
plb_cache_mem_addr  out  KEY_WIDTH  lookup key
plb_cache_mem_we  out  1  tied to 0
plb_cache_mem_valid  in  1  response valid; responses arrive in order
plb_cache_mem_rdata  in  1  hit flag (1 = hit)
hit_count_o  out  CNT_WIDTH  saturating count of hits
miss_count_o  out  CNT_WIDTH  saturating count of misses

Behaviour:
- Reset (asynchronous): all entries invalid; pointers, occupancy, drop_cnt and counters = 0. master_valid = 0, mem_req = 0, slave_ready = 0.
- Storage: circular FIFO of DEPTH entries. Each entry holds {data, resolved, hit}. Pointers: wr_ptr (allocate), rsp_ptr (next entry to resolve), rd_ptr (head). All wrap modulo DEPTH.
- Full condition: occupancy == DEPTH.
- Lookup path (plb_en_i = 1):
  - mem_req = slave_valid & ~full & ~flush.
  - mem_addr = slave_data[KEY_LSB +: KEY_WIDTH].
  - slave_ready = mem_req & mem_gnt.
  - On acceptance: push entry with resolved = 0.
- Bypass path (plb_en_i = 0):
  - mem_req = 0; slave_ready = slave_valid & ~full & ~flush.
  - On acceptance: push entry with resolved = 1, hit = 0.
  - The entry still waits behind older unresolved entries.
- Response handling, when mem_valid & drop_cnt == 0:
  - Write hit = rdata into entry rsp_ptr and set resolved.
  - Advance rsp_ptr past that entry and past any bypass entries after it.
  - Increment the hit or miss counter; counters saturate at all-ones.
- Output:
  - master_valid = head entry valid & resolved.
  - master_data = head data with bit WALK_BIT replaced by hit.
  - Pop when master_valid & master_ready.
- Latency: acceptance at edge T0 and mem_valid in the following cycle gives master_valid at T2 at the earliest. Bypass gives master_valid in the cycle after acceptance.
- Push and pop in the same cycle when full: a new push is allowed only if ~full at the start of the cycle. No fall-through.
- Flush:
  - All entries are invalidated at the next edge.
  - drop_cnt += number of lookups granted but not yet answered, including any grant issued in the flush cycle (none, since mem_req is gated by flush).
  - While drop_cnt > 0, each mem_valid decrements drop_cnt and leaves counters and entries untouched.
  - New requests are allowed during draining, but the occupancy check counts drop_cnt, so occupancy + drop_cnt ≤ DEPTH always.
- A mem_valid with no outstanding lookup is ignored. A simulation assertion must fire on it.
- plb_en_i is sampled per transaction at acceptance; toggling it mid-stream must not reorder outputs.

Test Plan:
1. DEPTH=4, gnt=1, rdata alternating 1,0,1,0, one-cycle response, master_ready=1 → 4 outputs in order with WALK_BIT 1,0,1,0; first output at T2; hit_count=2, miss_count=2.
2. Issue 4 lookups with no responses → slave_ready=0 on the 5th. Return 4 responses, hold master_ready=0 → master_valid=1 and no further accept until pops occur.
3. plb_en_i=0 for transaction B placed between lookups A and C; A's response delayed 5 cycles → output order A,B,C; B has WALK_BIT=0; mem_req never asserted for B.
4. Two lookups outstanding, then flush → master_valid=0 next cycle, drop_cnt=2. The next 2 mem_valid change no counter. A new lookup D issued during the drain resolves correctly from the 3rd response.
5. CNT_WIDTH=2 with 5 hits → hit_count_o holds at 3.
6. Assert rst_i with 3 entries held, mid-response → all outputs 0 immediately; after release, the first new lookup behaves as in scenario 1.

Source files
------------

// File: rtl/plb_lookup_queue.sv
// PLB lookup queue: issues in-order PLB lookups for walker transactions, holds up to
// DEPTH of them, and emits each with its walking bit resolved (hit -> SKIP, miss -> DO).
module plb_lookup_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEY_LSB    = 0,
  parameter int unsigned KEY_WIDTH  = 32,
  parameter int unsigned WALK_BIT   = 0,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  plb_lookup_slave_valid,
  output logic                  plb_lookup_slave_ready,
  input  logic [DATA_WIDTH-1:0] plb_lookup_slave_data,
  output logic                  plb_lookup_master_valid,
  input  logic                  plb_lookup_master_ready,
  output logic [DATA_WIDTH-1:0] plb_lookup_master_data,
  input  logic                  plb_lookup_control_flush,
  input  logic                  plb_en_i,
  output logic                  plb_cache_mem_req,
  input  logic                  plb_cache_mem_gnt,
  output logic [KEY_WIDTH-1:0]  plb_cache_mem_addr,
  output logic                  plb_cache_mem_we,
  input  logic                  plb_cache_mem_valid,
  input  logic                  plb_cache_mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_SUM = (CW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      resolved_q, resolved_d;
  logic [DEPTH-1:0]      hit_q, hit_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  occ_q, occ_d;
  cnt_t                  out_cnt_q, out_cnt_d;
  cnt_t                  drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic                  full;
  logic [CW:0]           fill;
  logic                  can_push;
  logic                  push;
  logic                  pop;
  logic                  rsp_found;
  ptr_t                  rsp_ptr;
  ptr_t                  scan_idx;
  logic                  rsp_live;
  logic                  rsp_drop;
  logic [DATA_WIDTH-1:0] head_data;

  // Lookups still being drained after a flush occupy capacity until answered.
  assign fill     = {1'b0, occ_q} + {1'b0, drop_cnt_q};
  assign full     = (fill >= DEPTH_SUM);
  assign can_push = plb_lookup_slave_valid & ~full & ~plb_lookup_control_flush & ~rst_i;

  assign plb_cache_mem_req      = plb_en_i & can_push;
  assign plb_cache_mem_addr     = plb_lookup_slave_data[KEY_LSB +: KEY_WIDTH];
  assign plb_cache_mem_we       = 1'b0;
  assign plb_lookup_slave_ready = plb_en_i ? (can_push & plb_cache_mem_gnt) : can_push;
  assign push                   = plb_lookup_slave_valid & plb_lookup_slave_ready;

  assign plb_lookup_master_valid = (occ_q != '0) & resolved_q[rd_ptr_q];
  assign pop                     = plb_lookup_master_valid & plb_lookup_master_ready;

  always_comb begin
    head_data           = data_q[rd_ptr_q];
    head_data[WALK_BIT] = hit_q[rd_ptr_q];
    plb_lookup_master_data = head_data;
  end

  // The response target is the oldest held entry still unresolved; scanning from the
  // head skips bypass entries without a separately maintained response pointer.
  always_comb begin
    rsp_found = 1'b0;
    rsp_ptr   = rd_ptr_q;
    scan_idx  = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + ptr_t'(i);
      if (!rsp_found && (cnt_t'(i) < occ_q) && !resolved_q[scan_idx]) begin
        rsp_found = 1'b1;
        rsp_ptr   = scan_idx;
      end
    end
  end

  assign rsp_drop = plb_cache_mem_valid & (drop_cnt_q != '0);
  assign rsp_live = plb_cache_mem_valid & (drop_cnt_q == '0) & rsp_found;

  always_comb begin
    data_d     = data_q;
    resolved_d = resolved_q;
    hit_d      = hit_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    occ_d      = occ_q + cnt_t'(push) - cnt_t'(pop);
    out_cnt_d  = out_cnt_q + cnt_t'(push & plb_en_i) - cnt_t'(rsp_live);
    drop_cnt_d = drop_cnt_q - cnt_t'(rsp_drop);

    if (rsp_live) begin
      resolved_d[rsp_ptr] = 1'b1;
      hit_d[rsp_ptr]      = plb_cache_mem_rdata;
      if (plb_cache_mem_rdata) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (push) begin
      data_d[wr_ptr_q]     = plb_lookup_slave_data;
      resolved_d[wr_ptr_q] = ~plb_en_i;
      hit_d[wr_ptr_q]      = 1'b0;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end

    // Lookups still unanswered at flush time become drops; push is blocked by flush.
    if (plb_lookup_control_flush) begin
      resolved_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      out_cnt_d  = '0;
      drop_cnt_d = drop_cnt_q - cnt_t'(rsp_drop) + out_cnt_q - cnt_t'(rsp_live);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
      resolved_q <= '0;
      hit_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      resolved_q <= resolved_d;
      hit_q      <= hit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;

  stray_rsp_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(plb_cache_mem_valid && (drop_cnt_q == '0) && (out_cnt_q == '0)));

endmodule

// File: tb/tb_plb_lookup_queue.sv
// Directed bench for plb_lookup_queue: ordering, backpressure, bypass, flush drain,
// counter saturation (second instance with 2-bit counters) and mid-traffic reset.
module tb_plb_lookup_queue;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  int          checks = 0;
  int          failures = 0;

  logic        s_valid, s_ready, m_valid, m_ready, flush, en;
  logic [31:0] s_data, m_data, mem_addr;
  logic        mem_req, mem_gnt, mem_we, mem_valid, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  logic        s_valid2, s_ready2, m_valid2, m_ready2;
  logic [31:0] s_data2, m_data2, mem_addr2;
  logic        mem_req2, mem_we2, mem_valid2;
  logic [1:0]  hit_cnt2, miss_cnt2;

  always #5 clk_i = ~clk_i;

  plb_lookup_queue #(.DATA_WIDTH(32), .KEY_LSB(0), .KEY_WIDTH(32), .WALK_BIT(0),
                     .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .plb_lookup_slave_valid(s_valid), .plb_lookup_slave_ready(s_ready),
    .plb_lookup_slave_data(s_data), .plb_lookup_master_valid(m_valid),
    .plb_lookup_master_ready(m_ready), .plb_lookup_master_data(m_data),
    .plb_lookup_control_flush(flush), .plb_en_i(en),
    .plb_cache_mem_req(mem_req), .plb_cache_mem_gnt(mem_gnt),
    .plb_cache_mem_addr(mem_addr), .plb_cache_mem_we(mem_we),
    .plb_cache_mem_valid(mem_valid), .plb_cache_mem_rdata(mem_rdata),
    .hit_count_o(hit_cnt), .miss_count_o(miss_cnt));

  plb_lookup_queue #(.DATA_WIDTH(32), .KEY_LSB(0), .KEY_WIDTH(32), .WALK_BIT(0),
                     .DEPTH(4), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .plb_lookup_slave_valid(s_valid2), .plb_lookup_slave_ready(s_ready2),
    .plb_lookup_slave_data(s_data2), .plb_lookup_master_valid(m_valid2),
    .plb_lookup_master_ready(m_ready2), .plb_lookup_master_data(m_data2),
    .plb_lookup_control_flush(1'b0), .plb_en_i(1'b1),
    .plb_cache_mem_req(mem_req2), .plb_cache_mem_gnt(1'b1),
    .plb_cache_mem_addr(mem_addr2), .plb_cache_mem_we(mem_we2),
    .plb_cache_mem_valid(mem_valid2), .plb_cache_mem_rdata(1'b1),
    .hit_count_o(hit_cnt2), .miss_count_o(miss_cnt2));

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%b exp=0", m_valid); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_sready got=%b exp=0", s_ready); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0)
      begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    repeat (2) step();
    rst_i = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] din [4];
    logic [31:0] dexp [4];
    logic        rsp [4];
    din  = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0000, 32'h4444_0001};
    dexp = '{32'h1111_0001, 32'h2222_0000, 32'h3333_0001, 32'h4444_0000};
    rsp  = '{1'b1, 1'b0, 1'b1, 1'b0};
    m_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      s_valid   = (k < 4);
      s_data    = (k < 4) ? din[k] : 32'h0;
      mem_valid = (k >= 1 && k <= 4);
      mem_rdata = (k >= 1 && k <= 4) ? rsp[k-1] : 1'b0;
      #1;
      if (k < 4) begin
        checks++; if (s_ready !== 1'b1 || mem_addr !== din[k])
          begin failures++; $display("FAIL stream_accept k=%0d got=%b/%h exp=1/%h", k, s_ready, mem_addr, din[k]); end
      end
      if (k >= 2 && k <= 5) begin
        checks++; if (m_valid !== 1'b1 || m_data !== dexp[k-2])
          begin failures++; $display("FAIL stream_out k=%0d got=%b/%h exp=1/%h", k, m_valid, m_data, dexp[k-2]); end
      end else begin
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL stream_idle k=%0d got=%b exp=0", k, m_valid); end
      end
      step();
    end
    checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd2)
      begin failures++; $display("FAIL stream_cnt got=%0d/%0d exp=2/2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_full_backpressure();
    int pops = 0;
    m_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'h5000_0000 + i;
      #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL full_fill i=%0d got=%b exp=1", i, s_ready); end
      step();
    end
    s_data = 32'h5000_0004;
    #1;
    checks++; if (s_ready !== 1'b0 || mem_req !== 1'b0)
      begin failures++; $display("FAIL full_fifth got=%b/%b exp=0/0", s_ready, mem_req); end
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL full_rsp i=%0d got=%b exp=0", i, s_ready); end
      step();
    end
    mem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0)
        begin failures++; $display("FAIL full_stall i=%0d got=%b/%b exp=1/0", i, m_valid, s_ready); end
      step();
    end
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL full_popcycle got=%b exp=0", s_ready); end
    if (m_valid) pops++;
    step();
    m_ready = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL full_afterpop got=%b exp=1", s_ready); end
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      m_ready = 1'b1; mem_valid = (k == 0); mem_rdata = 1'b0;
      #1;
      if (m_valid) pops++;
      step();
    end
    mem_valid = 1'b0;
    checks++; if (pops != 5 || m_valid !== 1'b0)
      begin failures++; $display("FAIL full_drain got=%0d/%b exp=5/0", pops, m_valid); end
    checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd7)
      begin failures++; $display("FAIL full_cnt got=%0d/%0d exp=2/7", hit_cnt, miss_cnt); end
  endtask

  task automatic test_bypass_order();
    m_ready = 1'b1; mem_valid = 1'b0;
    s_valid = 1'b1; en = 1'b1; s_data = 32'hAAAA_0000;
    #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL byp_reqA got=%b exp=1", mem_req); end
    step();
    en = 1'b0; s_data = 32'hBBBB_0001;
    #1;
    checks++; if (mem_req !== 1'b0 || s_ready !== 1'b1)
      begin failures++; $display("FAIL byp_reqB got=%b/%b exp=0/1", mem_req, s_ready); end
    step();
    en = 1'b1; s_data = 32'hCCCC_0001;
    #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL byp_reqC got=%b exp=1", mem_req); end
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL byp_wait k=%0d got=%b exp=0", k, m_valid); end
      step();
    end
    mem_valid = 1'b1; mem_rdata = 1'b1;
    step();
    mem_rdata = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'hAAAA_0001)
      begin failures++; $display("FAIL byp_outA got=%b/%h exp=1/aaaa0001", m_valid, m_data); end
    step();
    mem_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'hBBBB_0000)
      begin failures++; $display("FAIL byp_outB got=%b/%h exp=1/bbbb0000", m_valid, m_data); end
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== 32'hCCCC_0000)
      begin failures++; $display("FAIL byp_outC got=%b/%h exp=1/cccc0000", m_valid, m_data); end
    step();
    checks++; if (m_valid !== 1'b0 || hit_cnt !== 16'd3 || miss_cnt !== 16'd8)
      begin failures++; $display("FAIL byp_end got=%b/%0d/%0d exp=0/3/8", m_valid, hit_cnt, miss_cnt); end
  endtask

  task automatic test_flush_drain();
    m_ready = 1'b1; mem_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'h6000_0000 + i;
      step();
    end
    flush = 1'b1; s_data = 32'h6000_0002;
    #1;
    checks++; if (s_ready !== 1'b0 || mem_req !== 1'b0)
      begin failures++; $display("FAIL flush_gate got=%b/%b exp=0/0", s_ready, mem_req); end
    step();
    flush = 1'b0; s_data = 32'hDDDD_0001; mem_valid = 1'b1; mem_rdata = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || dut.drop_cnt_q !== 3'd2)
      begin failures++; $display("FAIL flush_state got=%b/%0d exp=0/2", m_valid, dut.drop_cnt_q); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL flush_newreq got=%b exp=1", s_ready); end
    step();
    s_valid = 1'b0;
    step();
    mem_rdata = 1'b0;
    #1;
    checks++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd8)
      begin failures++; $display("FAIL flush_dropcnt got=%0d/%0d exp=3/8", hit_cnt, miss_cnt); end
    step();
    mem_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'hDDDD_0000 || miss_cnt !== 16'd9)
      begin failures++; $display("FAIL flush_D got=%b/%h/%0d exp=1/dddd0000/9", m_valid, m_data, miss_cnt); end
    step();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_end got=%b exp=0", m_valid); end
  endtask

  task automatic test_saturate();
    m_ready2 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      s_valid2   = (k < 5);
      s_data2    = 32'h7000_0000 + k;
      mem_valid2 = (k >= 1 && k <= 5);
      #1;
      if (k == 4) begin
        checks++; if (hit_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_mid got=%0d exp=3", hit_cnt2); end
      end
      step();
    end
    mem_valid2 = 1'b0; s_valid2 = 1'b0;
    checks++; if (hit_cnt2 !== 2'd3 || miss_cnt2 !== 2'd0)
      begin failures++; $display("FAIL sat_end got=%0d/%0d exp=3/0", hit_cnt2, miss_cnt2); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = 32'h8000_0000 + k;
      mem_valid = (k >= 1); mem_rdata = (k == 1);
      step();
    end
    s_data = 32'h8000_0003; mem_valid = 1'b1; mem_rdata = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b1 || s_ready !== 1'b1)
      begin failures++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", m_valid, s_ready); end
    #1 rst_i = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || mem_req !== 1'b0 || s_ready !== 1'b0)
      begin failures++; $display("FAIL rstmid_out got=%b/%b/%b exp=0/0/0", m_valid, mem_req, s_ready); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0)
      begin failures++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    mem_valid = 1'b0; s_valid = 1'b0;
    repeat (2) step();
    rst_i = 1'b0;
    s_valid = 1'b1; s_data = 32'h9999_0000;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rstmid_acc got=%b exp=1", s_ready); end
    step();
    s_valid = 1'b0; mem_valid = 1'b1; mem_rdata = 1'b1; m_ready = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_early got=%b exp=0", m_valid); end
    step();
    mem_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h9999_0001 || hit_cnt !== 16'd1)
      begin failures++; $display("FAIL rstmid_out1 got=%b/%h/%0d exp=1/99990001/1", m_valid, m_data, hit_cnt); end
    step();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_end got=%b exp=0", m_valid); end
  endtask

  initial begin
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush = 1'b0; en = 1'b1;
    mem_gnt = 1'b1; mem_valid = 1'b0; mem_rdata = 1'b0;
    s_valid2 = 1'b0; s_data2 = '0; m_ready2 = 1'b0; mem_valid2 = 1'b0;
    test_reset();
    test_stream();
    test_full_backpressure();
    test_bypass_order();
    test_flush_drain();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
